mgt_01_nr_sqrt_seq: RTL and testbench
=====================================

MGT_01_NR_SQRT_SEQ -- requirements
Module: mgt_01_nr_sqrt_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 48, radicand width; SHALL be even and >= 4.
REQ-002 Parameter BITS_PER_CYCLE, default 1, root bits resolved per COMPUTE cycle; SHALL be 1, 2 or 4 and SHALL divide DATA_WIDTH/2.
REQ-003 Derived: OUT_WIDTH = DATA_WIDTH/2; N = OUT_WIDTH/BITS_PER_CYCLE.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 clk_en_i  in  1  global enable; low freezes every register.
REQ-007 start_i  in  1  request; sampled only in IDLE or DONE.
REQ-008 kill_i  in  1  abort of the operation in flight.
REQ-009 radicand_i  in  DATA_WIDTH  unsigned operand, captured on an accepted start.
REQ-010 root_o  out  OUT_WIDTH  floor(sqrt(radicand)).
REQ-011 remainder_o  out  OUT_WIDTH+1  radicand - root^2, unsigned.
REQ-012 valid_o  out  1  result-ready pulse.
REQ-013 busy_o  out  1  high in COMPUTE and FIX.
REQ-014 exact_o  out  1  remainder_o == 0 (present only with the configuration macro).

Function
REQ-015 FSM states IDLE, COMPUTE, FIX, DONE; every transition is qualified by clk_en_i = 1.
REQ-016 IDLE or DONE with start_i = 1 and kill_i = 0: capture radicand_i, clear partial root and remainder, load counter with N-1, go to COMPUTE.
REQ-017 COMPUTE: each cycle performs BITS_PER_CYCLE non-restoring steps (add or subtract by sign of the partial remainder); counter 0 -> FIX, otherwise decrement.
REQ-018 FIX: if the partial remainder is negative, add (2*root+1) once; then register root_o and remainder_o; go to DONE.
REQ-019 DONE: valid_o = 1; without an accepted start go to IDLE next enabled cycle.
REQ-020 Latency: valid_o is high exactly N+2 enabled cycles after the start-accepting edge (N+2 = 26 at the defaults).
REQ-021 valid_o is high for exactly one enabled cycle per completed operation; while clk_en_i = 0 it holds its value.
REQ-022 root_o, remainder_o (and exact_o) hold the last result until the FIX of the next operation; they do not change during COMPUTE.
REQ-023 start_i in COMPUTE or FIX is ignored; radicand_i changes after capture have no effect.
REQ-024 Start in DONE is accepted in the same cycle valid_o is high (back-to-back throughput of one result per N+2 cycles).
REQ-025 kill_i = 1 in COMPUTE or FIX: next state IDLE, busy_o drops, no valid_o, outputs keep the previous result.
REQ-026 kill_i = 1 together with start_i: kill wins, start not accepted.
REQ-027 Internal remainder datapath is OUT_WIDTH+2 bits signed; final remainder_o SHALL satisfy 0 <= remainder_o <= 2*root_o.

Reset
REQ-028 rst_i = 1 at a rising edge: state IDLE, root_o = 0, remainder_o = 0, valid_o = 0, busy_o = 0, exact_o = 0, counter 0; regardless of clk_en_i.
REQ-029 Reset during COMPUTE or FIX discards the operation; no valid_o is produced for it.

Configuration
REQ-030 Macro MGT_01_SQRT_EXACT_FLAG_EN: when defined, port exact_o exists and is registered with root_o in FIX as (final remainder == 0).
REQ-031 When not defined, the port and its register are absent; all other behaviour and latency are identical.

Verification
REQ-032 Defaults, radicand 0x800000000000 -> valid_o after 26 cycles, root_o 0xB504F3 (11863283), remainder_o 4817239, exact_o 0.
REQ-033 Radicand 0xFFFFFFFFFFFF -> root_o 0xFFFFFF, remainder_o 0x1FFFFFE; radicand 144 -> root_o 12, remainder_o 0, exact_o 1; radicand 0 -> root 0, remainder 0, exact_o 1.
REQ-034 kill_i pulsed on 10th COMPUTE cycle -> IDLE next cycle, busy_o 0, no valid_o, root_o/remainder_o unchanged; start_i during COMPUTE ignored.
REQ-035 Back-to-back: start held high through DONE -> second valid_o exactly 26 cycles after the first, correct second result.
REQ-036 clk_en_i low for 5 cycles mid-COMPUTE -> valid_o delayed by exactly 5 cycles, same result; rst_i mid-COMPUTE -> all outputs 0 next edge.
REQ-037 BITS_PER_CYCLE = 2 and 4, radicand 0x800000000000 -> same results, valid_o after 14 and 8 cycles respectively.

Source files
------------

// File: rtl/mgt_01_nr_sqrt_seq.sv
// Sequential non-restoring integer square root.
// root_o = floor(sqrt(radicand)), remainder_o = radicand - root_o^2.
// BITS_PER_CYCLE root bits are resolved per COMPUTE cycle; a final FIX
// cycle corrects a negative partial remainder and registers the result.
// Optional feature: define MGT_01_SQRT_EXACT_FLAG_EN to add the exact_o port.
module mgt_01_nr_sqrt_seq #(
    parameter int DATA_WIDTH     = 48,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic                    start_i,
    input  logic                    kill_i,
    input  logic [DATA_WIDTH-1:0]   radicand_i,
    output logic [DATA_WIDTH/2-1:0] root_o,
    output logic [DATA_WIDTH/2:0]   remainder_o,
    output logic                    valid_o,
    output logic                    busy_o
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
   ,output logic                    exact_o
`endif
);

    localparam int OUT_WIDTH = DATA_WIDTH / 2;
    localparam int N         = OUT_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;
    localparam int RW        = OUT_WIDTH + 2;   // signed partial remainder width

    typedef enum logic [1:0] {IDLE, COMPUTE, FIX, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rad_q, rad_nxt;
    logic [OUT_WIDTH-1:0]  q_part, q_nxt;
    logic [RW-1:0]         r_part, r_nxt, r_fix;
    logic [RW-1:0]         step_shift;
    logic [1:0]            step_pair;
    logic                  accept, compute_go, fix_go;

    // Handshake qualifiers: kill always beats start and aborts work in flight.
    always_comb begin
        accept     = ((state == IDLE) || (state == DONE)) && start_i && !kill_i;
        compute_go = (state == COMPUTE) && !kill_i;
        fix_go     = (state == FIX) && !kill_i;
        busy_o     = (state == COMPUTE) || (state == FIX);
    end

    // Unrolled non-restoring steps: subtract (4q+1) when the partial remainder
    // is non-negative, add (4q+3) when negative; the new root bit is its sign.
    always_comb begin
        // NOTE: blocking assignments here chain one step into the next within
        // the same cycle; each variable gets a default first so no latch forms.
        rad_nxt    = rad_q;
        q_nxt      = q_part;
        r_nxt      = r_part;
        step_pair  = 2'b00;
        step_shift = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_pair  = rad_nxt[DATA_WIDTH-1 -: 2];
            rad_nxt    = rad_nxt << 2;
            step_shift = {r_nxt[OUT_WIDTH-1:0], step_pair};
            if (!r_nxt[RW-1])
                r_nxt = step_shift - {q_nxt, 2'b01};
            else
                r_nxt = step_shift + {q_nxt, 2'b11};
            q_nxt = {q_nxt[OUT_WIDTH-2:0], ~r_nxt[RW-1]};
        end
    end

    // Final correction: a negative remainder gets one (2q+1) added back.
    always_comb begin
        r_fix = r_part;
        if (r_part[RW-1])
            r_fix = r_part + {1'b0, q_part, 1'b1};
    end

    // State register; reset wins over the clock enable.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i)
            state <= IDLE;
        else if (clk_en_i)
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = accept ? COMPUTE : IDLE;
            COMPUTE: begin
                if (kill_i)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(0))
                    state_nxt = FIX;
            end
            FIX:        state_nxt = kill_i ? IDLE : DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers; results only move on a completed FIX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            rad_q       <= '0;
            q_part      <= '0;
            r_part      <= '0;
            root_o      <= '0;
            remainder_o <= '0;
            valid_o     <= 1'b0;
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
            exact_o     <= 1'b0;
`endif
        end else if (clk_en_i) begin
            valid_o <= 1'b0;
            if (accept) begin
                rad_q  <= radicand_i;
                q_part <= '0;
                r_part <= '0;
                cnt    <= CNT_W'(N - 1);
            end else if (compute_go) begin
                rad_q  <= rad_nxt;
                q_part <= q_nxt;
                r_part <= r_nxt;
                if (cnt != CNT_W'(0))
                    cnt <= cnt - 1'b1;
            end else if (fix_go) begin
                root_o      <= q_part;
                remainder_o <= r_fix[OUT_WIDTH:0];
                valid_o     <= 1'b1;
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
                exact_o     <= (r_fix == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_mgt_01_nr_sqrt_seq.sv
// Self-checking bench for mgt_01_nr_sqrt_seq: three instances (1, 2 and 4
// bits per cycle) share stimulus; results are compared against an integer
// square root computed directly from the definition.
module tb_mgt_01_nr_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst_i, clk_en_i, start_i, kill_i;
    logic [47:0] radicand_i;
    logic [23:0] root1, root2, root4;
    logic [24:0] rem1, rem2, rem4;
    logic        valid1, valid2, valid4, busy1, busy2, busy4;
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
    logic        exact1, exact2, exact4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mgt_01_nr_sqrt_seq #(.DATA_WIDTH(48), .BITS_PER_CYCLE(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i), .start_i(start_i),
        .kill_i(kill_i), .radicand_i(radicand_i), .root_o(root1),
        .remainder_o(rem1), .valid_o(valid1), .busy_o(busy1)
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
       ,.exact_o(exact1)
`endif
    );
    mgt_01_nr_sqrt_seq #(.DATA_WIDTH(48), .BITS_PER_CYCLE(2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i), .start_i(start_i),
        .kill_i(kill_i), .radicand_i(radicand_i), .root_o(root2),
        .remainder_o(rem2), .valid_o(valid2), .busy_o(busy2)
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
       ,.exact_o(exact2)
`endif
    );
    mgt_01_nr_sqrt_seq #(.DATA_WIDTH(48), .BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i), .start_i(start_i),
        .kill_i(kill_i), .radicand_i(radicand_i), .root_o(root4),
        .remainder_o(rem4), .valid_o(valid4), .busy_o(busy4)
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
       ,.exact_o(exact4)
`endif
    );

    // Reference: largest q with q*q <= x, built greedily bit by bit.
    function automatic logic [23:0] ref_root(input logic [47:0] x);
        longint unsigned q = 0;
        longint unsigned t;
        for (int b = 23; b >= 0; b--) begin
            t = q | (64'd1 << b);
            if (t * t <= {16'd0, x}) q = t;
        end
        return q[23:0];
    endfunction

    function automatic logic [24:0] ref_rem(input logic [47:0] x);
        longint unsigned q = {40'd0, ref_root(x)};
        longint unsigned r = {16'd0, x} - q * q;
        return r[24:0];
    endfunction

    function automatic logic [47:0] rand48();
        logic [63:0] t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    // One operation on all three instances; optional start re-pulse at cycle rp.
    task automatic run_op(input logic [47:0] x, input int rp);
        logic [23:0] er = ref_root(x);
        logic [24:0] em = ref_rem(x);
        int lat1 = -1, lat2 = -1, lat4 = -1, nv1 = 0;
        logic [23:0] g1 = '0, g2 = '0, g4 = '0;
        logic [24:0] m1 = '0, m2 = '0, m4 = '0;
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
        logic e1 = 1'b0;
`endif
        @(negedge clk);
        radicand_i = x;
        start_i    = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin start_i = 1'b0; radicand_i = ~x; end
            if (rp > 0 && c == rp) start_i = 1'b1;
            if (rp > 0 && c == rp + 1) start_i = 1'b0;
            if (valid1) begin
                nv1++;
                if (lat1 < 0) begin
                    lat1 = c; g1 = root1; m1 = rem1;
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
                    e1 = exact1;
`endif
                end
            end
            if (valid2 && lat2 < 0) begin lat2 = c; g2 = root2; m2 = rem2; end
            if (valid4 && lat4 < 0) begin lat4 = c; g4 = root4; m4 = rem4; end
        end
        checks++; if (lat1 !== 26) begin errors++; $display("FAIL lat_bpc1 x=%h got %0d want 26", x, lat1); end
        checks++; if (g1 !== er) begin errors++; $display("FAIL root_bpc1 x=%h got %0d want %0d", x, g1, er); end
        checks++; if (m1 !== em) begin errors++; $display("FAIL rem_bpc1 x=%h got %0d want %0d", x, m1, em); end
        checks++; if (nv1 !== 1) begin errors++; $display("FAIL valid_pulses x=%h got %0d want 1", x, nv1); end
        checks++; if (lat2 !== 14) begin errors++; $display("FAIL lat_bpc2 x=%h got %0d want 14", x, lat2); end
        checks++; if (g2 !== er || m2 !== em) begin errors++; $display("FAIL res_bpc2 x=%h got %0d/%0d want %0d/%0d", x, g2, m2, er, em); end
        checks++; if (lat4 !== 8) begin errors++; $display("FAIL lat_bpc4 x=%h got %0d want 8", x, lat4); end
        checks++; if (g4 !== er || m4 !== em) begin errors++; $display("FAIL res_bpc4 x=%h got %0d/%0d want %0d/%0d", x, g4, m4, er, em); end
        checks++; if (root1 !== er || rem1 !== em) begin errors++; $display("FAIL hold_after x=%h got %0d/%0d want %0d/%0d", x, root1, rem1, er, em); end
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
        checks++; if (e1 !== (em == 25'd0)) begin errors++; $display("FAIL exact x=%h got %0b want %0b", x, e1, em == 25'd0); end
`endif
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clk_en_i = 1'b0; start_i = 1'b0; kill_i = 1'b0; radicand_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (root1 !== 24'd0 || rem1 !== 25'd0) begin errors++; $display("FAIL reset_result got %0d/%0d want 0/0", root1, rem1); end
        checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_flags got v=%b b=%b want 0/0", valid1, busy1); end
`ifdef MGT_01_SQRT_EXACT_FLAG_EN
        checks++; if (exact1 !== 1'b0) begin errors++; $display("FAIL reset_exact got %b want 0", exact1); end
`endif
        rst_i = 1'b0; clk_en_i = 1'b1;
    endtask

    task automatic test_directed();
        run_op(48'h800000000000, 0);
        checks++; if (root1 !== 24'hB504F3 || rem1 !== 25'd4817239) begin errors++; $display("FAIL known_2p47 got %0d/%0d want 11863283/4817239", root1, rem1); end
        run_op(48'hFFFFFFFFFFFF, 0);
        checks++; if (root1 !== 24'hFFFFFF || rem1 !== 25'h1FFFFFE) begin errors++; $display("FAIL known_max got %h/%h want ffffff/1fffffe", root1, rem1); end
        run_op(48'd144, 0);
        checks++; if (root1 !== 24'd12 || rem1 !== 25'd0) begin errors++; $display("FAIL known_144 got %0d/%0d want 12/0", root1, rem1); end
        run_op(48'd0, 0);
        run_op(48'd3, 0);
        run_op(48'd4, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) run_op(rand48() >> ($urandom_range(0, 40)), (k % 3 == 0) ? 5 : 0);
    endtask

    task automatic test_kill();
        logic [47:0] x = rand48();
        int nv = 0;
        run_op(48'd144, 0);
        @(negedge clk);
        radicand_i = x; start_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (c == 5) begin start_i = 1'b1; radicand_i = ~x; end
            if (c == 6) begin
                start_i = 1'b0;
                checks++; if (busy1 !== 1'b1 || root1 !== 24'd12) begin errors++; $display("FAIL compute_hold got b=%b root=%0d want 1/12", busy1, root1); end
            end
            if (c == 10) kill_i = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        kill_i = 1'b0;
        checks++; if (busy1 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL kill_idle got b=%b v=%b want 0/0", busy1, valid1); end
        checks++; if (root1 !== 24'd12 || rem1 !== 25'd0) begin errors++; $display("FAIL kill_keep got %0d/%0d want 12/0", root1, rem1); end
        for (int c = 0; c < 30; c++) begin @(posedge clk); @(negedge clk); if (valid1) nv++; end
        checks++; if (nv !== 0) begin errors++; $display("FAIL kill_no_valid got %0d want 0", nv); end
    endtask

    task automatic test_clk_en();
        logic [47:0] x = rand48();
        int lat = -1;
        @(negedge clk);
        radicand_i = x; start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (c == 5) clk_en_i = 1'b0;
            if (c == 10) clk_en_i = 1'b1;
            if (valid1) begin lat = c; break; end
        end
        checks++; if (lat !== 31) begin errors++; $display("FAIL clken_latency got %0d want 31", lat); end
        checks++; if (root1 !== ref_root(x) || rem1 !== ref_rem(x)) begin errors++; $display("FAIL clken_result got %0d/%0d want %0d/%0d", root1, rem1, ref_root(x), ref_rem(x)); end
        clk_en_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL clken_valid_hold cycle %0d got %b want 1", k, valid1); end
        end
        clk_en_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL clken_release got v=%b b=%b want 0/0", valid1, busy1); end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [47:0] x = rand48();
        logic [47:0] y = rand48();
        int t1 = -1, t2 = -1;
        logic [23:0] r1 = '0, r2 = '0;
        logic [24:0] m1 = '0, m2 = '0;
        @(negedge clk);
        radicand_i = x; start_i = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) radicand_i = y;
            if (valid1) begin
                if (t1 < 0) begin t1 = c; r1 = root1; m1 = rem1; end
                else begin t2 = c; r2 = root2; r2 = root1; m2 = rem1; start_i = 1'b0; break; end
            end
        end
        start_i = 1'b0;
        checks++; if (t1 !== 26 || t2 !== 52) begin errors++; $display("FAIL b2b_timing got %0d,%0d want 26,52", t1, t2); end
        checks++; if (r1 !== ref_root(x) || m1 !== ref_rem(x)) begin errors++; $display("FAIL b2b_first got %0d/%0d want %0d/%0d", r1, m1, ref_root(x), ref_rem(x)); end
        checks++; if (r2 !== ref_root(y) || m2 !== ref_rem(y)) begin errors++; $display("FAIL b2b_second got %0d/%0d want %0d/%0d", r2, m2, ref_root(y), ref_rem(y)); end
        repeat (30) @(posedge clk);
    endtask

    task automatic test_kill_start_idle();
        int nv = 0;
        @(negedge clk);
        start_i = 1'b1; kill_i = 1'b1; radicand_i = rand48();
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; kill_i = 1'b0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL kill_start got busy=%b want 0", busy1); end
        for (int c = 0; c < 30; c++) begin @(posedge clk); @(negedge clk); if (valid1) nv++; end
        checks++; if (nv !== 0) begin errors++; $display("FAIL kill_start_valid got %0d want 0", nv); end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        run_op(48'h800000000000, 0);
        @(negedge clk);
        radicand_i = rand48(); start_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
        end
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (root1 !== 24'd0 || rem1 !== 25'd0 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL reset_mid got root=%0d rem=%0d v=%b b=%b want all 0", root1, rem1, valid1, busy1);
        end
        for (int c = 0; c < 35; c++) begin @(posedge clk); @(negedge clk); if (valid1) nv++; end
        checks++; if (nv !== 0) begin errors++; $display("FAIL reset_mid_valid got %0d want 0", nv); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_clk_en();
        test_back_to_back();
        test_kill_start_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
